mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 16-bit unsigned multiply/divide execution unit.
- Sits directly upstream of the register file write port and produces its write-back data.
- Drives the data for the destination register (low product / quotient) and the R0 side-channel (high product / remainder), plus a one-cycle write strobe and destination index.
- One bit per cycle, shift-add / restoring-divide; start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 16, operand and result-half width in bits.
- REG_ADDR_W, 4, register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MUL, 1 = DIV.
- operand_a  input  WIDTH  multiplicand / dividend.
- operand_b  input  WIDTH  multiplier / divisor.
- dest_in  input  REG_ADDR_W  destination register index.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; doubles as register-file write enable.
- result_lo  output  WIDTH  product[15:0] or quotient; register-file data write port.
- result_hi  output  WIDTH  product[31:16] or remainder; register-file R0 write port.
- dest_out  output  REG_ADDR_W  latched dest_in; register-file write index.
- div_by_zero  output  1  valid with done; high for DIV with operand_b == 0.

Behaviour:
- Reset (async, any state, including mid-CALC):
  - State goes to IDLE; no done pulse is emitted.
  - busy = 0, done = 0, result_lo = 0, result_hi = 0, dest_out = 0, div_by_zero = 0.
  - Iteration counter and internal accumulators clear.
- States: IDLE, CALC, DONE.
- IDLE:
  - start = 1 at edge E0 latches op, operands and dest_in; next state is CALC, count = 0.
  - Exception: DIV with operand_b == 0 goes straight to DONE.
- CALC: one iteration per edge, count increments.
  - When the iteration at count == WIDTH-1 completes, next state is DONE.
  - Exactly WIDTH CALC edges.
- DONE: done = 1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - Start cycle is cycle 0; done is high in cycle WIDTH+1 (cycle 17 at default).
  - Divide-by-zero: done is high in cycle 1.
- start is ignored while busy; no queuing. start in the DONE cycle is ignored, so back-to-back requests are spaced at least WIDTH+2 cycles apart.
- MUL (unsigned): {result_hi, result_lo} = a*b, full 2*WIDTH result, no overflow possible.
  - Per iteration: if the multiplier LSB is 1, add the multiplicand into the upper half using a WIDTH+1-bit add (carry kept); then shift {carry, hi, lo} right by 1.
- DIV (unsigned, restoring): result_lo = a / b, result_hi = a % b.
  - Per iteration: shift {rem, quo} left by 1; trial-subtract b from rem using a WIDTH+1-bit subtract; if non-negative, commit and set quo LSB = 1.
- Divide-by-zero: result_lo = all ones, result_hi = operand_a, div_by_zero = 1.
- Outputs result_lo, result_hi, dest_out and div_by_zero:
  - Update only on entry to DONE.
  - Hold stable until the next DONE; downstream may sample them any time after done.
- div_by_zero clears on the next accepted start.
- Intermediate accumulator values are never visible on the result ports.
- A single WIDTH+1-bit adder/subtractor is shared by MUL and DIV.

Decomposition:
- Shared package:
  - op encodings OP_MUL = 1'b0, OP_DIV = 1'b1.
  - State encodings IDLE/CALC/DONE.
  - Constant CNT_W = clog2(WIDTH).
- No sub-module required. The shared adder/subtractor may be factored as addsub_unit (WIDTH+1 bits, sub control) if reused by the ALU.

Test Plan:
- MUL 0x7B18 * 0x245B, dest_in = 3 -> done in cycle 17 with result_hi = 0x117B, result_lo = 0x2188, dest_out = 3, div_by_zero = 0; busy high cycles 1-17.
- MUL 0xFFFF * 0xFFFF -> result_hi = 0xFFFE, result_lo = 0x0001; MUL 0x1234 * 0x0000 -> both halves 0x0000.
- DIV 0xFF0F / 0x0051 -> result_lo = 0x0326, result_hi = 0x0009 in cycle 17; DIV 0x0005 / 0x0007 -> quotient 0x0000, remainder 0x0005.
- DIV 0x00FF / 0x0000 -> done in cycle 1, result_lo = 0xFFFF, result_hi = 0x00FF, div_by_zero = 1; next valid start clears div_by_zero.
- start pulsed again in cycles 5 and 17 of a running MUL -> ignored; exactly one done pulse; results from the first operation only.
- reset_n low in cycle 8 of a DIV -> outputs zero immediately, no done; fresh MUL after reset completes correctly in 17 cycles.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   OP_MUL / OP_DIV       : encodings of the op input
//   ST_IDLE/ST_CALC/ST_DONE : controller state encodings
//   DATA_W                : default operand / result-half width
//   CNT_W                 : iteration counter width for DATA_W
package mul_div_unit_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DATA_W);

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / restoring-divide unit, one bit per cycle.
// Feeds the register-file write port: result_lo goes to the destination
// register, result_hi to the R0 side-channel, done is the write enable.
//
// Ports:
//   clk, reset_n          : clock (rising edge), async active-low reset
//   start, op             : request (sampled only in IDLE), 0=MUL 1=DIV
//   operand_a, operand_b  : multiplicand/dividend, multiplier/divisor
//   dest_in               : destination register index for this request
//   busy                  : high while in CALC or DONE
//   done                  : one-cycle pulse, register-file write strobe
//   result_lo, result_hi  : low product/quotient, high product/remainder
//   dest_out              : destination index belonging to the results
//   div_by_zero           : DIV with operand_b == 0, valid with done
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result_lo,
    output logic [WIDTH-1:0]      result_hi,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic                  div_by_zero
);

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    logic                  opReg;
    logic [REG_ADDR_W-1:0] destReg;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]      opndReg;
    // MUL: accHi = running upper product, accLo = multiplier shifting out
    //      while the product low bits shift in.
    // DIV: accHi = partial remainder, accLo = dividend shifting out while
    //      quotient bits shift in.
    logic [WIDTH-1:0]      accHi;
    logic [WIDTH-1:0]      accLo;

    logic [WIDTH:0]        addA;
    logic [WIDTH:0]        addB;
    logic [WIDTH:0]        addSum;
    logic [WIDTH:0]        mulShift;
    logic [WIDTH-1:0]      nextHi;
    logic [WIDTH-1:0]      nextLo;
    logic                  lastIter;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign lastIter = (count == CNT_W'(WIDTH - 1));

    // One WIDTH+1-bit adder/subtractor shared by both operations:
    // subtract is add of the inverted operand plus one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        addA = {1'b0, accHi};
        if (opReg == OP_DIV) begin
            // Left shift of {rem, quo} folded into the adder input.
            addA = {accHi, accLo[WIDTH-1]};
        end
        addB   = {1'b0, opndReg};
        addSum = addA + (addB ^ {(WIDTH+1){opReg}}) + (WIDTH+1)'(opReg);
    end

    always_comb begin
        mulShift = addA;
        nextHi   = '0;
        nextLo   = '0;
        if (opReg == OP_MUL) begin
            if (accLo[0]) begin
                mulShift = addSum;
            end
            // Shift {carry, hi, lo} right by one.
            nextHi = mulShift[WIDTH:1];
            nextLo = {mulShift[0], accLo[WIDTH-1:1]};
        end else if (!addSum[WIDTH]) begin
            // Trial subtract non-negative: commit and set quotient bit.
            nextHi = addSum[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], 1'b1};
        end else begin
            nextHi = addA[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            opReg       <= OP_MUL;
            destReg     <= '0;
            opndReg     <= '0;
            accHi       <= '0;
            accLo       <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            dest_out    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opReg   <= op;
                        destReg <= dest_in;
                        count   <= '0;
                        accHi   <= '0;
                        opndReg <= (op == OP_DIV) ? operand_b : operand_a;
                        accLo   <= (op == OP_DIV) ? operand_a : operand_b;
                        if (op == OP_DIV && operand_b == '0) begin
                            // Divide by zero skips CALC entirely.
                            state       <= ST_DONE;
                            result_lo   <= '1;
                            result_hi   <= operand_a;
                            dest_out    <= dest_in;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= ST_CALC;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        // Results become visible only on entry to DONE.
                        state     <= ST_DONE;
                        result_hi <= nextHi;
                        result_lo <= nextLo;
                        dest_out  <= destReg;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit. Each request is started in cycle 0
// and observed mid-cycle (on the falling edge) for a fixed window.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  dest_in;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [3:0]  dest_out;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_in     (dest_in),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .dest_out    (dest_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one request started in cycle 0 and watches cycles 1..24.
    // With inject set, extra start pulses carrying different operands are
    // driven in cycles 5 and 17; they must be ignored.
    task automatic run_op(input string name, input logic opIn,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] dest, input int expDone,
                          input logic [15:0] expHi, input logic [15:0] expLo,
                          input logic expDbz, input bit inject,
                          output logic dbzCycle1);
        int          doneCycle = -1;
        int          doneCount = 0;
        int          busyErrs  = 0;
        logic [15:0] hiSeen    = '0;
        logic [15:0] loSeen    = '0;
        logic [3:0]  destSeen  = '0;
        logic        dbzSeen   = 1'b0;
        dbzCycle1 = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        op        = opIn;
        operand_a = a;
        operand_b = b;
        dest_in   = dest;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) dbzCycle1 = div_by_zero;
            if (busy !== ((c <= expDone) ? 1'b1 : 1'b0)) busyErrs++;
            if (done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = c;
                    hiSeen    = result_hi;
                    loSeen    = result_lo;
                    destSeen  = dest_out;
                    dbzSeen   = div_by_zero;
                end
            end
            if (inject && (c == 5 || c == 17)) begin
                start     = 1'b1;
                op        = OP_MUL;
                operand_a = 16'hFFFF;
                operand_b = 16'hFFFF;
                dest_in   = 4'd9;
            end
        end
        check({name, " done_cycle"}, doneCycle, expDone);
        check({name, " done_count"}, doneCount, 1);
        check({name, " busy_errs"}, busyErrs, 0);
        check({name, " result_hi"}, hiSeen, expHi);
        check({name, " result_lo"}, loSeen, expLo);
        check({name, " dest_out"}, destSeen, dest);
        check({name, " div_by_zero"}, dbzSeen, expDbz);
        check({name, " hi_held"}, result_hi, expHi);
        check({name, " lo_held"}, result_lo, expLo);
    endtask

    initial begin
        logic dbz1;
        int   doneAfterReset;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = OP_MUL;
        operand_a = '0;
        operand_b = '0;
        dest_in   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result_lo", result_lo, 0);
        check("reset result_hi", result_hi, 0);
        check("reset dest_out", dest_out, 0);
        check("reset dbz", div_by_zero, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mul_basic", OP_MUL, 16'h7B18, 16'h245B, 4'd3, 17, 16'h117B, 16'h2188, 1'b0, 1'b0, dbz1);
        run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 4'd1, 17, 16'hFFFE, 16'h0001, 1'b0, 1'b0, dbz1);
        run_op("mul_zero", OP_MUL, 16'h1234, 16'h0000, 4'd2, 17, 16'h0000, 16'h0000, 1'b0, 1'b0, dbz1);
        run_op("div_basic", OP_DIV, 16'hFF0F, 16'h0051, 4'd4, 17, 16'h0009, 16'h0326, 1'b0, 1'b0, dbz1);
        run_op("div_small", OP_DIV, 16'h0005, 16'h0007, 4'd6, 17, 16'h0005, 16'h0000, 1'b0, 1'b0, dbz1);
        run_op("div_zero", OP_DIV, 16'h00FF, 16'h0000, 4'd8, 1, 16'h00FF, 16'hFFFF, 1'b1, 1'b0, dbz1);
        run_op("dbz_clear", OP_MUL, 16'h0003, 16'h0005, 4'd10, 17, 16'h0000, 16'h000F, 1'b0, 1'b0, dbz1);
        check("dbz_clear on_start", dbz1, 0);
        run_op("mul_ignore_start", OP_MUL, 16'h1234, 16'h5678, 4'd5, 17, 16'h0626, 16'h0060, 1'b0, 1'b1, dbz1);

        // Reset in cycle 8 of a divide: outputs clear at once, no done.
        doneAfterReset = 0;
        @(negedge clk);
        start     = 1'b1;
        op        = OP_DIV;
        operand_a = 16'hFF0F;
        operand_b = 16'h0051;
        dest_in   = 4'd7;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset busy", busy, 0);
        check("mid_reset done", done, 0);
        check("mid_reset result_lo", result_lo, 0);
        check("mid_reset result_hi", result_hi, 0);
        check("mid_reset dest_out", dest_out, 0);
        check("mid_reset dbz", div_by_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) doneAfterReset++;
        end
        check("post_reset no_done", doneAfterReset, 0);
        run_op("mul_after_reset", OP_MUL, 16'h7B18, 16'h245B, 4'd2, 17, 16'h117B, 16'h2188, 1'b0, 1'b0, dbz1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
